// File: rtl/entity_pkg.sv
// rtl/entity_pkg.sv - shared constants, types and helpers for entity motion
// Purpose: direction codes from the PIO, facing encoding, FSM state type and
//          playfield bound defaults used by entity_motion_ctrl and its stepper.
// Ports:   none (package).
package entity_pkg;

   localparam logic [2:0] DIR_STOP  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   localparam logic [1:0] FACE_UP    = 2'd0;
   localparam logic [1:0] FACE_DOWN  = 2'd1;
   localparam logic [1:0] FACE_LEFT  = 2'd2;
   localparam logic [1:0] FACE_RIGHT = 2'd3;

   localparam int PF_X_MIN  = 0;
   localparam int PF_X_MAX  = 624;
   localparam int PF_Y_MIN  = 0;
   localparam int PF_Y_MAX  = 464;
   localparam int PF_X_INIT = 312;
   localparam int PF_Y_INIT = 232;

   typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_ANIM} state_t;

   // Stop and the reserved codes keep whatever facing the entity already had.
   function automatic logic [1:0] face_of(input logic [2:0] d, input logic [1:0] cur);
      case (d)
         DIR_UP:    face_of = FACE_UP;
         DIR_DOWN:  face_of = FACE_DOWN;
         DIR_LEFT:  face_of = FACE_LEFT;
         DIR_RIGHT: face_of = FACE_RIGHT;
         DIR_STOP:  face_of = cur;
         default:   face_of = cur;
      endcase
   endfunction

endpackage

// File: rtl/entity_axis_stepper.sv
// rtl/entity_axis_stepper.sv - single-axis one-pixel step with bounds check and clamp
// Purpose: combinational helper; proposes a 1 px move inside [MIN, MAX] and
//          clamps an arbitrary load value into the same range.
// Ports:   pos          current coordinate
//          inc / dec    request +1 / -1 this cycle (at most one set)
//          load_val     raw value for a position load
//          step_pos     coordinate after the candidate step
//          stepped      candidate step was applied
//          load_clamped load_val clamped to [MIN, MAX]
module entity_axis_stepper #(
   parameter int W   = 10,
   parameter int MIN = 0,
   parameter int MAX = 624
) (
   input  logic [W-1:0] pos,
   input  logic         inc,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] step_pos,
   output logic         stepped,
   output logic [W-1:0] load_clamped
);

   // One extra bit so bound comparisons never depend on wrap-around.
   localparam logic [W:0] MIN_E = (W+1)'(MIN);
   localparam logic [W:0] MAX_E = (W+1)'(MAX);

   logic [W:0] pos_e;
   logic [W:0] load_e;
   logic       can_inc;
   logic       can_dec;

   assign pos_e  = {1'b0, pos};
   assign load_e = {1'b0, load_val};

   // Bounds are checked on the current value, before the step is taken.
   assign can_inc = inc && (pos_e < MAX_E);
   assign can_dec = dec && (pos_e > MIN_E);
   assign stepped = can_inc || can_dec;

   assign step_pos = can_inc ? pos + W'(1) :
                     can_dec ? pos - W'(1) : pos;

   assign load_clamped = ((load_e + 1'b1) <= MIN_E) ? MIN_E[W-1:0] :
                         (load_e > MAX_E)           ? MAX_E[W-1:0] : load_val;

endmodule

// File: rtl/entity_motion_ctrl.sv
// rtl/entity_motion_ctrl.sv - frame-stepped entity position, facing and walk animation
// Purpose: on each frame_tick, moves the entity STEP_PX pixels (one per cycle)
//          in the PIO direction, clamped to the playfield, then updates the
//          walk-animation phase. load_pos forces a clamped position.
// Ports:   clk, reset_n (async, active-low)
//          dir, frame_tick, load_pos, load_x, load_y   inputs
//          pos_x, pos_y, facing, moving, anim_frame    sprite renderer outputs
//          busy, update_done, overrun                  status
module entity_motion_ctrl
   import entity_pkg::*;
#(
   parameter int X_W      = 10,
   parameter int Y_W      = 9,
   parameter int X_MIN    = PF_X_MIN,
   parameter int X_MAX    = PF_X_MAX,
   parameter int Y_MIN    = PF_Y_MIN,
   parameter int Y_MAX    = PF_Y_MAX,
   parameter int X_INIT   = PF_X_INIT,
   parameter int Y_INIT   = PF_Y_INIT,
   parameter int STEP_PX  = 2,
   parameter int ANIM_DIV = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [2:0]     dir,
   input  logic           frame_tick,
   input  logic           load_pos,
   input  logic [X_W-1:0] load_x,
   input  logic [Y_W-1:0] load_y,
   output logic [X_W-1:0] pos_x,
   output logic [Y_W-1:0] pos_y,
   output logic [1:0]     facing,
   output logic           moving,
   output logic [1:0]     anim_frame,
   output logic           busy,
   output logic           update_done,
   output logic           overrun
);

   localparam int CNT_W = $clog2(STEP_PX + 1);
   localparam int DIV_W = $clog2(ANIM_DIV + 1);

   state_t           state, state_d;
   logic [2:0]       dir_q, dir_d;
   logic [CNT_W-1:0] step_cnt, cnt_d;
   logic             moved_q, moved_d;
   logic [DIV_W-1:0] anim_div, div_d;
   logic [X_W-1:0]   pos_x_d;
   logic [Y_W-1:0]   pos_y_d;
   logic [1:0]       facing_d, anim_d;
   logic             moving_d, busy_d, done_d, overrun_d;

   logic [X_W-1:0]   x_step, x_load;
   logic [Y_W-1:0]   y_step, y_load;
   logic             x_stepped, y_stepped;

   entity_axis_stepper #(.W(X_W), .MIN(X_MIN), .MAX(X_MAX)) u_x_axis (
      .pos(pos_x), .inc(dir_q == DIR_RIGHT), .dec(dir_q == DIR_LEFT),
      .load_val(load_x), .step_pos(x_step), .stepped(x_stepped), .load_clamped(x_load)
   );

   entity_axis_stepper #(.W(Y_W), .MIN(Y_MIN), .MAX(Y_MAX)) u_y_axis (
      .pos(pos_y), .inc(dir_q == DIR_DOWN), .dec(dir_q == DIR_UP),
      .load_val(load_y), .step_pos(y_step), .stepped(y_stepped), .load_clamped(y_load)
   );

   always_comb begin
      state_d   = state;
      dir_d     = dir_q;
      cnt_d     = step_cnt;
      moved_d   = moved_q;
      div_d     = anim_div;
      pos_x_d   = pos_x;
      pos_y_d   = pos_y;
      facing_d  = facing;
      moving_d  = moving;
      anim_d    = anim_frame;
      busy_d    = busy;
      done_d    = 1'b0;
      overrun_d = overrun;

      if (load_pos) begin
         // Load wins over everything, including a coincident tick.
         pos_x_d  = x_load;
         pos_y_d  = y_load;
         state_d  = ST_IDLE;
         moving_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         if (frame_tick && state != ST_IDLE)
            overrun_d = 1'b1;
         case (state)
            ST_IDLE: begin
               if (frame_tick) begin
                  dir_d    = dir;
                  cnt_d    = '0;
                  moved_d  = 1'b0;
                  facing_d = face_of(dir, facing);
                  busy_d   = 1'b1;
                  state_d  = ST_MOVE;
               end
            end
            ST_MOVE: begin
               pos_x_d = x_step;
               pos_y_d = y_step;
               if (x_stepped || y_stepped)
                  moved_d = 1'b1;
               if (step_cnt == CNT_W'(STEP_PX - 1))
                  state_d = ST_ANIM;
               else
                  cnt_d = step_cnt + CNT_W'(1);
            end
            ST_ANIM: begin
               moving_d = moved_q;
               if (moved_q) begin
                  if (anim_div == DIV_W'(ANIM_DIV - 1)) begin
                     div_d  = '0;
                     anim_d = anim_frame + 2'd1;
                  end else begin
                     div_d = anim_div + DIV_W'(1);
                  end
               end else begin
                  div_d  = '0;
                  anim_d = 2'd0;
               end
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         dir_q       <= DIR_STOP;
         step_cnt    <= '0;
         moved_q     <= 1'b0;
         anim_div    <= '0;
         pos_x       <= X_W'(X_INIT);
         pos_y       <= Y_W'(Y_INIT);
         facing      <= FACE_DOWN;
         moving      <= 1'b0;
         anim_frame  <= 2'd0;
         busy        <= 1'b0;
         update_done <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_d;
         dir_q       <= dir_d;
         step_cnt    <= cnt_d;
         moved_q     <= moved_d;
         anim_div    <= div_d;
         pos_x       <= pos_x_d;
         pos_y       <= pos_y_d;
         facing      <= facing_d;
         moving      <= moving_d;
         anim_frame  <= anim_d;
         busy        <= busy_d;
         update_done <= done_d;
         overrun     <= overrun_d;
      end
   end

endmodule
